// File: rtl/traffic_light_pkg.sv
// Shared junction-light definitions: aspects, phase codes,
// default dwells and fault bit positions.
package traffic_light_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [2:0] S1 = 3'd0;
  localparam logic [2:0] S2 = 3'd1;
  localparam logic [2:0] S3 = 3'd2;
  localparam logic [2:0] S4 = 3'd3;
  localparam logic [2:0] S5 = 3'd4;
  localparam logic [2:0] S6 = 3'd5;
  localparam logic [2:0] PH_NONE = 3'd7;

  localparam int DW1_DEF = 8;
  localparam int DW2_DEF = 3;
  localparam int DW3_DEF = 6;
  localparam int DW4_DEF = 3;
  localparam int DW5_DEF = 4;
  localparam int DW6_DEF = 3;
  localparam int DWELL_MAX_DEF = 15;

  localparam int ERR_SEQ   = 0;
  localparam int ERR_DWELL = 1;
  localparam int ERR_ILL   = 2;
  localparam int ERR_CONF  = 3;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] mt;
    logic [2:0] m2;
    logic [2:0] s;
  } lights_t;

  typedef enum logic {
    ACQUIRE,
    TRACK
  } mon_state_t;

  function automatic logic [2:0] next_phase(
    input logic [2:0] p
  );
    return (p == S6) ? S1 : p + 3'd1;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light bus as seen by the monitor, plus its status outputs.
// master = bus driver / supervisor, slave = monitor.
interface traffic_light_monitor_if;

  logic [2:0] light_M1;
  logic [2:0] light_MT;
  logic [2:0] light_M2;
  logic [2:0] light_S;
  logic       clr_err;
  logic [2:0] phase;
  logic       locked;
  logic [3:0] dwell;
  logic [7:0] cycle_cnt;
  logic [3:0] err_pulse;
  logic [3:0] err_status;

  modport master (
    output light_M1, light_MT,
    output light_M2, light_S,
    output clr_err,
    input  phase, locked, dwell,
    input  cycle_cnt,
    input  err_pulse, err_status
  );

  modport slave (
    input  light_M1, light_MT,
    input  light_M2, light_S,
    input  clr_err,
    output phase, locked, dwell,
    output cycle_cnt,
    output err_pulse, err_status
  );

endinterface

// File: rtl/traffic_light_decoder.sv
// Combinational aspect decoder: four approaches to a phase
// code plus illegal / conflicting-green flags.
module traffic_light_decoder
  import traffic_light_pkg::*;
(
  input  lights_t    lights,
  output logic [2:0] phase,
  output logic       illegal,
  output logic       conflict
);

  logic main_go;

  always_comb begin
    phase = PH_NONE;
    unique case (1'b1)
      (lights == {GRN, RED, GRN, RED}): phase = S1;
      (lights == {GRN, RED, YEL, RED}): phase = S2;
      (lights == {GRN, GRN, RED, RED}): phase = S3;
      (lights == {YEL, YEL, RED, RED}): phase = S4;
      (lights == {RED, RED, RED, GRN}): phase = S5;
      (lights == {RED, RED, RED, YEL}): phase = S6;
      default:                          phase = PH_NONE;
    endcase
  end

  assign main_go = (lights.m1 != RED) ||
                   (lights.mt != RED) ||
                   (lights.m2 != RED);

  // Cross-traffic conflicts; every one is also illegal.
  assign conflict =
    ((lights.s != RED) && main_go) ||
    ((lights.mt != RED) && (lights.m2 != RED));

  assign illegal = (phase == PH_NONE);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive light-bus checker: decodes the six-phase sequence,
// measures dwell and raises sequence/dwell/aspect faults.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int DW1       = DW1_DEF,
  parameter int DW2       = DW2_DEF,
  parameter int DW3       = DW3_DEF,
  parameter int DW4       = DW4_DEF,
  parameter int DW5       = DW5_DEF,
  parameter int DW6       = DW6_DEF,
  parameter int DWELL_MAX = DWELL_MAX_DEF
) (
  input logic clk,
  input logic rst,
  traffic_light_monitor_if.slave bus
);

  localparam logic [3:0] DMAX = 4'(DWELL_MAX);

  lights_t    sa_q;
  logic       sa_vld;
  logic [2:0] dec_ph;
  logic       dec_ill;
  logic       dec_conf;

  mon_state_t state_q, state_d;
  logic [2:0] prev_q;
  logic [2:0] phase_q, phase_d;
  logic [3:0] dwell_q, dwell_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pulse_q, pulse_d;
  logic [3:0] status_q;

  logic [3:0] dwell_inc;
  logic [3:0] dw_cur;
  logic       acq_hit;
  logic       same_ph;
  logic       seq_f;
  logic       dw_f;

  traffic_light_decoder u_dec (
    .lights   (sa_q),
    .phase    (dec_ph),
    .illegal  (dec_ill),
    .conflict (dec_conf)
  );

  assign dwell_inc = (dwell_q == 4'hf) ? 4'hf : dwell_q + 4'd1;
  assign same_ph   = (dec_ph == phase_q);

  // Lock only on a valid-to-valid edge so the partial phase
  // seen on entry is never judged.
  assign acq_hit = sa_vld && !dec_ill &&
                   (prev_q != PH_NONE) &&
                   (dec_ph != prev_q);

  always_comb begin
    dw_cur = 4'(DW1);
    unique case (phase_q)
      S2:      dw_cur = 4'(DW2);
      S3:      dw_cur = 4'(DW3);
      S4:      dw_cur = 4'(DW4);
      S5:      dw_cur = 4'(DW5);
      S6:      dw_cur = 4'(DW6);
      default: dw_cur = 4'(DW1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= {RED, RED, RED, RED};
      sa_vld   <= 1'b0;
      state_q  <= ACQUIRE;
      prev_q   <= PH_NONE;
      phase_q  <= PH_NONE;
      dwell_q  <= '0;
      cnt_q    <= '0;
      pulse_q  <= '0;
      status_q <= '0;
    end else begin
      sa_q     <= {bus.light_M1, bus.light_MT,
                   bus.light_M2, bus.light_S};
      sa_vld   <= 1'b1;
      state_q  <= state_d;
      if (sa_vld) prev_q <= dec_ph;
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      status_q <= (bus.clr_err ? 4'b0 : status_q) | pulse_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sa_vld) begin
      unique case (state_q)
        ACQUIRE:
          if (acq_hit) state_d = TRACK;
        TRACK:
          if (dec_ill || (same_ph && dwell_inc == DMAX))
            state_d = ACQUIRE;
      endcase
    end
  end

  always_comb begin
    phase_d = phase_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    seq_f   = 1'b0;
    dw_f    = 1'b0;
    if (sa_vld) begin
      if (dec_ill) begin
        pulse_d[ERR_ILL]  = 1'b1;
        pulse_d[ERR_CONF] = dec_conf;
        phase_d = PH_NONE;
        dwell_d = '0;
      end else begin
        unique case (state_q)
          ACQUIRE: begin
            if (acq_hit) begin
              phase_d = dec_ph;
              dwell_d = 4'd1;
            end
          end
          TRACK: begin
            if (same_ph) begin
              dwell_d = dwell_inc;
              pulse_d[ERR_DWELL] = (dwell_inc == DMAX);
            end else begin
              seq_f = (dec_ph != next_phase(phase_q));
              dw_f  = (dwell_q != dw_cur);
              pulse_d[ERR_SEQ]   = seq_f;
              pulse_d[ERR_DWELL] = dw_f;
              phase_d = dec_ph;
              dwell_d = 4'd1;
              if (phase_q == S6 && dec_ph == S1 &&
                  !seq_f && !dw_f)
                cnt_d = cnt_q + 8'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.phase      = phase_q;
  assign bus.locked     = (state_q == TRACK);
  assign bus.dwell      = dwell_q;
  assign bus.cycle_cnt  = cnt_q;
  assign bus.err_pulse  = pulse_q;
  assign bus.err_status = status_q;

endmodule
